ptw_mem_arbiter: RTL and testbench

- Shares one memory read port between two SV32 page-table walkers: the IFU-side MMU and the LSU-side MMU.
- Each walker issues level-held PTE read requests on its mmu_mem_* interface. The arbiter grants one walker at a time, drives the shared port, routes the response back, and absorbs flushes and hung reads.
- Sits between the two mmu instances and the bus/cache bridge.

---
 rtl/ptw_mem_arbiter_pkg.sv | 17 +
 rtl/ptw_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared encodings for the page-table-walker memory arbiter.
package ptw_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      PTW_ARB_IDLE  = 2'd0,
      PTW_ARB_ISSUE = 2'd1,
      PTW_ARB_WAIT  = 2'd2,
      PTW_ARB_RESP  = 2'd3
   } ptw_arb_state_e;

   localparam logic PTW_OWN_IFU = 1'b0;
   localparam logic PTW_OWN_LSU = 1'b1;

   // Default number of WAIT cycles before a hung read is abandoned.
   localparam int PTW_ARB_TIMEOUT = 255;

endpackage

// File: rtl/ptw_mem_arbiter.sv
// Two-way round-robin arbiter sharing one memory read port between the
// IFU-side and LSU-side SV32 page-table walkers.
module ptw_mem_arbiter
   import ptw_mem_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = PTW_ARB_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ifu_mem_req_i,
   input  logic [AW-1:0] ifu_mem_addr_i,
   output logic [DW-1:0] ifu_mem_rdata_o,
   output logic          ifu_mem_rvalid_o,
   input  logic          ifu_flush_i,
   input  logic          lsu_mem_req_i,
   input  logic [AW-1:0] lsu_mem_addr_i,
   output logic [DW-1:0] lsu_mem_rdata_o,
   output logic          lsu_mem_rvalid_o,
   input  logic          lsu_flush_i,
   output logic          mem_req_o,
   output logic [AW-1:0] mem_addr_o,
   input  logic          mem_ready_i,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_rvalid_i,
   output logic          owner_o,
   output logic          busy_o,
   output logic          timeout_o
);

   // Timeout counter is 8 bits wide; TIMEOUT must lie in 1..255.
   localparam logic [7:0] LP_TIMEOUT = TIMEOUT[7:0];

   ptw_arb_state_e r_state;
   logic           r_last_grant;
   logic           r_owner;
   logic           r_mem_req;
   logic [AW-1:0]  r_mem_addr;
   logic [DW-1:0]  r_ifu_rdata;
   logic           r_ifu_rvalid;
   logic [DW-1:0]  r_lsu_rdata;
   logic           r_lsu_rvalid;
   logic           r_timeout;
   logic           r_drop;
   logic [7:0]     r_cnt;

   logic           w_ifu_elig;
   logic           w_lsu_elig;
   logic           w_pick_lsu;
   logic           w_owner_flush;
   logic           w_drop_now;
   logic [7:0]     w_cnt_inc;
   logic           w_timeout_hit;
   logic           w_wait_done;
   logic           w_deliver;
   logic [DW-1:0]  w_resp_data;

   // Round-robin pick and WAIT-state completion terms.
   always_comb begin
      w_ifu_elig    = ifu_mem_req_i & ~ifu_flush_i;
      w_lsu_elig    = lsu_mem_req_i & ~lsu_flush_i;
      // LSU wins when alone, or on contention when IFU had the last grant.
      w_pick_lsu    = w_lsu_elig & (~w_ifu_elig | (r_last_grant == PTW_OWN_IFU));
      w_owner_flush = (r_owner == PTW_OWN_LSU) ? lsu_flush_i : ifu_flush_i;
      // A flush arriving in the same cycle as the data still suppresses it.
      w_drop_now    = r_drop | w_owner_flush;
      // r_cnt counts completed WAIT cycles, so w_cnt_inc is the current one.
      w_cnt_inc     = r_cnt + 8'd1;
      w_timeout_hit = (w_cnt_inc == LP_TIMEOUT);
      w_wait_done   = (r_state == PTW_ARB_WAIT) & (mem_rvalid_i | w_timeout_hit);
      w_deliver     = w_wait_done & ~w_drop_now;
      // Abandoned reads return an all-zero (invalid) PTE.
      w_resp_data   = mem_rvalid_i ? mem_rdata_i : '0;
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= PTW_ARB_IDLE;
         r_last_grant <= PTW_OWN_LSU;
         r_owner      <= PTW_OWN_IFU;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
         r_ifu_rdata  <= '0;
         r_ifu_rvalid <= 1'b0;
         r_lsu_rdata  <= '0;
         r_lsu_rvalid <= 1'b0;
         r_timeout    <= 1'b0;
         r_drop       <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_ifu_rvalid <= 1'b0;
         r_lsu_rvalid <= 1'b0;
         r_timeout    <= 1'b0;
         if (w_deliver) begin
            if (r_owner == PTW_OWN_LSU) begin
               r_lsu_rdata  <= w_resp_data;
               r_lsu_rvalid <= 1'b1;
            end else begin
               r_ifu_rdata  <= w_resp_data;
               r_ifu_rvalid <= 1'b1;
            end
         end
         case (r_state)
            PTW_ARB_IDLE: begin
               if (w_ifu_elig | w_lsu_elig) begin
                  r_owner      <= w_pick_lsu;
                  r_last_grant <= w_pick_lsu;
                  r_mem_addr   <= w_pick_lsu ? lsu_mem_addr_i : ifu_mem_addr_i;
                  r_mem_req    <= 1'b1;
                  r_state      <= PTW_ARB_ISSUE;
               end
            end
            PTW_ARB_ISSUE: begin
               // Once accepted the read is in flight; a flush only discards its data.
               if (mem_ready_i) begin
                  r_mem_req <= 1'b0;
                  r_cnt     <= '0;
                  r_drop    <= w_owner_flush;
                  r_state   <= PTW_ARB_WAIT;
               end else if (w_owner_flush) begin
                  r_mem_req <= 1'b0;
                  r_state   <= PTW_ARB_IDLE;
               end
            end
            PTW_ARB_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (w_owner_flush) r_drop <= 1'b1;
               if (mem_rvalid_i) begin
                  r_state <= PTW_ARB_RESP;
               end else if (w_timeout_hit) begin
                  r_timeout <= 1'b1;
                  r_state   <= PTW_ARB_RESP;
               end
            end
            // Idle gap lets the walker update its request before re-arbitration.
            default: r_state <= PTW_ARB_IDLE;
         endcase
      end
   end

   assign ifu_mem_rdata_o  = r_ifu_rdata;
   assign ifu_mem_rvalid_o = r_ifu_rvalid;
   assign lsu_mem_rdata_o  = r_lsu_rdata;
   assign lsu_mem_rvalid_o = r_lsu_rvalid;
   assign mem_req_o        = r_mem_req;
   assign mem_addr_o       = r_mem_addr;
   assign owner_o          = r_owner;
   assign busy_o           = (r_state != PTW_ARB_IDLE);
   assign timeout_o        = r_timeout;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter (TIMEOUT=4).
module tb_ptw_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifu_req, lsu_req, ifu_flush, lsu_flush;
   logic [31:0] ifu_addr, lsu_addr;
   logic [31:0] ifu_rdata, lsu_rdata;
   logic        ifu_rvalid, lsu_rvalid;
   logic        mem_req, mem_ready, mem_rvalid;
   logic [31:0] mem_addr, mem_rdata;
   logic        owner, busy, tmo;

   int n_tests = 0;
   int n_fail  = 0;

   ptw_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_mem_req_i(ifu_req), .ifu_mem_addr_i(ifu_addr),
      .ifu_mem_rdata_o(ifu_rdata), .ifu_mem_rvalid_o(ifu_rvalid),
      .ifu_flush_i(ifu_flush),
      .lsu_mem_req_i(lsu_req), .lsu_mem_addr_i(lsu_addr),
      .lsu_mem_rdata_o(lsu_rdata), .lsu_mem_rvalid_o(lsu_rvalid),
      .lsu_flush_i(lsu_flush),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ready_i(mem_ready),
      .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
      .owner_o(owner), .busy_o(busy), .timeout_o(tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are checked 1 time unit after the rising edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bounded wait for the shared-port request; expiry counts as a failure.
   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (mem_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk1(tag, mem_req, 1'b1);
   endtask

   // One complete transaction with rvalid in the first WAIT cycle.
   task automatic do_txn(input logic exp_own, input logic [31:0] exp_addr,
                         input logic [31:0] data);
      wait_req("rr_req");
      chk1("rr_owner", owner, exp_own);
      chk32("rr_addr", mem_addr, exp_addr);
      mem_ready = 1'b1;
      tick();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      tick();
      mem_rvalid = 1'b0;
      chk1("rr_ifu_rvalid", ifu_rvalid, (exp_own == 1'b0));
      chk1("rr_lsu_rvalid", lsu_rvalid, (exp_own == 1'b1));
      chk32("rr_rdata", exp_own ? lsu_rdata : ifu_rdata, data);
      chk1("rr_resp_noreq", mem_req, 1'b0);
      tick();
      chk1("rr_idle_noreq", mem_req, 1'b0);
      chk1("rr_idle_busy", busy, 1'b0);
   endtask

   initial begin
      logic own_seq [4];
      rst = 1'b1;
      ifu_req = 1'b0; lsu_req = 1'b0; ifu_flush = 1'b0; lsu_flush = 1'b0;
      ifu_addr = '0; lsu_addr = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      tick();
      tick();
      // Reset state
      chk1("rst_mem_req", mem_req, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk1("rst_owner", owner, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_timeout", tmo, 1'b0);
      chk1("rst_ifu_rvalid", ifu_rvalid, 1'b0);
      chk32("rst_ifu_rdata", ifu_rdata, 32'h0);
      rst = 1'b0;

      // IFU-only request, data 3 WAIT cycles after acceptance
      ifu_req = 1'b1; ifu_addr = 32'h8000_1004;
      tick();
      chk1("t1_req", mem_req, 1'b1);
      chk32("t1_addr", mem_addr, 32'h8000_1004);
      chk1("t1_busy", busy, 1'b1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk1("t1_req_drop", mem_req, 1'b0);
      tick();
      tick();
      chk1("t1_no_early_rvalid", ifu_rvalid, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'h2000_00CF;
      tick();
      mem_rvalid = 1'b0; ifu_req = 1'b0;
      chk1("t1_rvalid", ifu_rvalid, 1'b1);
      chk32("t1_rdata", ifu_rdata, 32'h2000_00CF);
      chk1("t1_lsu_rvalid", lsu_rvalid, 1'b0);
      tick();
      chk1("t1_rvalid_pulse", ifu_rvalid, 1'b0);
      chk1("t1_busy_clr", busy, 1'b0);
      chk32("t1_rdata_hold", ifu_rdata, 32'h2000_00CF);

      // Contention from reset: IFU, LSU, IFU, LSU
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifu_req = 1'b1; ifu_addr = 32'h100;
      lsu_req = 1'b1; lsu_addr = 32'h200;
      own_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++)
         do_txn(own_seq[i], own_seq[i] ? 32'h200 : 32'h100, 32'hA000_0000 + i);
      ifu_req = 1'b0; lsu_req = 1'b0;
      tick();

      // IFU flush during WAIT, pending LSU then granted
      ifu_req = 1'b1; ifu_addr = 32'h300;
      lsu_req = 1'b1; lsu_addr = 32'h400;
      wait_req("t3_req");
      chk1("t3_owner_ifu", owner, 1'b0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; ifu_flush = 1'b1;
      tick();
      ifu_flush = 1'b0; ifu_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      chk1("t3_ifu_dropped", ifu_rvalid, 1'b0);
      chk1("t3_lsu_quiet", lsu_rvalid, 1'b0);
      chk32("t3_ifu_rdata_hold", ifu_rdata, 32'hA000_0002);
      tick();
      chk1("t3_idle", busy, 1'b0);
      tick();
      chk1("t3_lsu_req", mem_req, 1'b1);
      chk1("t3_owner_lsu", owner, 1'b1);
      chk32("t3_lsu_addr", mem_addr, 32'h400);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0; lsu_req = 1'b0;
      chk1("t3_lsu_rvalid", lsu_rvalid, 1'b1);
      chk32("t3_lsu_rdata", lsu_rdata, 32'h1234_5678);
      tick();

      // Flush in ISSUE without ready; stray rvalid in IDLE ignored
      ifu_req = 1'b1; ifu_addr = 32'h500;
      tick();
      chk1("t4_req", mem_req, 1'b1);
      ifu_flush = 1'b1; ifu_req = 1'b0;
      tick();
      ifu_flush = 1'b0;
      chk1("t4_req_drop", mem_req, 1'b0);
      chk1("t4_busy", busy, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'h77;
      tick();
      mem_rvalid = 1'b0;
      chk1("t4_ifu_rvalid", ifu_rvalid, 1'b0);
      chk1("t4_lsu_rvalid", lsu_rvalid, 1'b0);
      chk32("t4_ifu_rdata_hold", ifu_rdata, 32'hA000_0002);

      // Timeout on an LSU read (TIMEOUT=4)
      lsu_req = 1'b1; lsu_addr = 32'h600;
      tick();
      chk1("t5_owner", owner, 1'b1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      tick();
      chk1("t5_w4_timeout", tmo, 1'b0);
      chk1("t5_w4_busy", busy, 1'b1);
      tick();
      lsu_req = 1'b0;
      chk1("t5_timeout", tmo, 1'b1);
      chk1("t5_rvalid", lsu_rvalid, 1'b1);
      chk32("t5_rdata_zero", lsu_rdata, 32'h0);
      chk1("t5_resp_busy", busy, 1'b1);
      tick();
      chk1("t5_timeout_pulse", tmo, 1'b0);
      chk1("t5_busy_clr", busy, 1'b0);

      // Data arriving on the timeout cycle wins
      ifu_req = 1'b1; ifu_addr = 32'h700;
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      mem_rvalid = 1'b0; ifu_req = 1'b0;
      chk1("t5b_no_timeout", tmo, 1'b0);
      chk1("t5b_rvalid", ifu_rvalid, 1'b1);
      chk32("t5b_rdata", ifu_rdata, 32'hCAFE_0001);
      tick();

      // Synchronous reset mid-WAIT, late rvalid ignored, IFU wins afterwards
      lsu_req = 1'b1; lsu_addr = 32'hA00;
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      rst = 1'b1; ifu_req = 1'b1; ifu_addr = 32'h900;
      tick();
      rst = 1'b0;
      chk1("t6_req", mem_req, 1'b0);
      chk32("t6_addr", mem_addr, 32'h0);
      chk1("t6_owner", owner, 1'b0);
      chk1("t6_busy", busy, 1'b0);
      chk1("t6_timeout", tmo, 1'b0);
      chk32("t6_ifu_rdata", ifu_rdata, 32'h0);
      chk32("t6_lsu_rdata", lsu_rdata, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h55;
      tick();
      mem_rvalid = 1'b0;
      chk1("t6_late_ifu", ifu_rvalid, 1'b0);
      chk1("t6_late_lsu", lsu_rvalid, 1'b0);
      chk1("t6_grant_req", mem_req, 1'b1);
      chk1("t6_grant_ifu", owner, 1'b0);
      chk32("t6_grant_addr", mem_addr, 32'h900);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h66;
      tick();
      mem_rvalid = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0;
      chk1("t6_rvalid", ifu_rvalid, 1'b1);
      chk32("t6_rdata", ifu_rdata, 32'h66);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
